// File: rtl/rx_frame_controller.sv
// Frame sequencer behind the UART Rx deserializer: parity/stop check, FWFT output FIFO, sticky flags.
// Optional parity checking is enabled by defining RX_PARITY_CHECK_EN.
module rx_frame_controller #(
   parameter int unsigned INPUT_DATA_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH       = 4,
   parameter bit          PARITY_ODD       = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES   = 4096
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              serial_in_synced,
   input  logic                              sampling_strobe,
   input  logic                              is_parity_stage,
   input  logic                              data_is_valid,
   input  logic [INPUT_DATA_WIDTH-1:0]       received_data,
   input  logic                              rx_enable,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [INPUT_DATA_WIDTH-1:0]       out_data,
   output logic                              out_parity_error,
   output logic                              out_framing_error,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
   output logic                              overrun,
   output logic                              timeout,
   input  logic                              clear_flags
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] WD_ONE  = TW'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_PARITY,
      WAIT_STOP,
      PUSH
   } state_t;

   state_t                        state_q;
   logic [INPUT_DATA_WIDTH-1:0]   data_q;
   logic                          frm_err_q;
   logic [TW-1:0]                 wdog_q;
   logic                          timeout_q;
   logic                          overrun_q;
`ifdef RX_PARITY_CHECK_EN
   logic                          par_err_q;
`endif

   logic [AW-1:0]                 wr_q, wr_d;
   logic [AW-1:0]                 rd_q, rd_d;
   logic [CW-1:0]                 count_q, count_d;

   logic [INPUT_DATA_WIDTH-1:0]   mem_data [FIFO_DEPTH];
   logic                          mem_frm  [FIFO_DEPTH];
`ifdef RX_PARITY_CHECK_EN
   logic                          mem_par  [FIFO_DEPTH];
`endif

   logic push_req;
   logic push;
   logic pop;
   logic full;

   // Frame sequencer; a fresh data_is_valid always preempts the frame in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         data_q    <= '0;
         frm_err_q <= 1'b0;
         wdog_q    <= '0;
         timeout_q <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         if (clear_flags) begin
            timeout_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (data_is_valid && rx_enable) begin
                  data_q  <= received_data;
                  wdog_q  <= '0;
                  state_q <= WAIT_PARITY;
               end
            end
            WAIT_PARITY, WAIT_STOP: begin
               if (data_is_valid) begin
                  wdog_q <= '0;
                  if (rx_enable) begin
                     data_q  <= received_data;
                     state_q <= WAIT_PARITY;
                  end else begin
                     state_q <= IDLE;
                  end
               end else if (sampling_strobe && (state_q == WAIT_STOP || is_parity_stage)) begin
                  wdog_q <= '0;
                  if (state_q == WAIT_PARITY) begin
`ifdef RX_PARITY_CHECK_EN
                     par_err_q <= ((^data_q) ^ serial_in_synced) != PARITY_ODD;
`endif
                     state_q <= WAIT_STOP;
                  end else begin
                     frm_err_q <= !serial_in_synced;
                     state_q   <= PUSH;
                  end
               end else if (wdog_q == WD_LAST) begin
                  timeout_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  wdog_q <= wdog_q + WD_ONE;
               end
            end
            PUSH: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // A full FIFO still accepts the frame when the head leaves in the same cycle.
   always_comb begin
      push_req = (state_q == PUSH);
      full     = (count_q == CNT_FULL);
      pop      = (count_q != '0) && out_ready;
      push     = push_req && (!full || pop);
      wr_d     = push ? (wr_q + PTR_ONE) : wr_q;
      rd_d     = pop ? (rd_q + PTR_ONE) : rd_q;
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_q      <= '0;
         rd_q      <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         if (clear_flags) begin
            overrun_q <= 1'b0;
         end
         if (push_req && !push) begin
            overrun_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_q] <= data_q;
         mem_frm[wr_q]  <= frm_err_q;
`ifdef RX_PARITY_CHECK_EN
         mem_par[wr_q]  <= par_err_q;
`endif
      end
   end

   always_comb begin
      out_valid         = (count_q != '0);
      out_data          = out_valid ? mem_data[rd_q] : '0;
      out_framing_error = out_valid && mem_frm[rd_q];
`ifdef RX_PARITY_CHECK_EN
      out_parity_error  = out_valid && mem_par[rd_q];
`else
      out_parity_error  = 1'b0;
`endif
      fifo_count        = count_q;
      overrun           = overrun_q;
      timeout           = timeout_q;
   end

endmodule

// File: tb/tb_rx_frame_controller.sv
// Self-checking bench for rx_frame_controller: vector table plus scoreboarded corner sequences.
// Parity expectations follow RX_PARITY_CHECK_EN.
module tb_rx_frame_controller;

`ifdef RX_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       serial_in_synced;
   logic       sampling_strobe;
   logic       is_parity_stage;
   logic       data_is_valid;
   logic [7:0] received_data;
   logic       rx_enable;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_parity_error;
   logic       out_framing_error;
   logic [2:0] fifo_count;
   logic       overrun;
   logic       timeout;
   logic       clear_flags;

   rx_frame_controller #(
      .INPUT_DATA_WIDTH(8),
      .FIFO_DEPTH(4),
      .PARITY_ODD(1'b0),
      .TIMEOUT_CYCLES(4096)
   ) dut (
      .clk(clk),
      .reset(reset),
      .serial_in_synced(serial_in_synced),
      .sampling_strobe(sampling_strobe),
      .is_parity_stage(is_parity_stage),
      .data_is_valid(data_is_valid),
      .received_data(received_data),
      .rx_enable(rx_enable),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_parity_error(out_parity_error),
      .out_framing_error(out_framing_error),
      .fifo_count(fifo_count),
      .overrun(overrun),
      .timeout(timeout),
      .clear_flags(clear_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       frm;
      logic       par;
   } entry_t;

   typedef struct {
      logic [7:0] d;
      logic       pb;
      logic       sb;
      logic       ep;
      logic       ef;
   } vec_t;

   entry_t sb_q[$];
   vec_t   vec[5];
   int     checks = 0;
   int     errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns in the PUSH cycle, one cycle after the stop-bit strobe.
   task automatic send_frame(input logic [7:0] d, input logic pb, input logic sbit);
      data_is_valid = 1'b1;
      received_data = d;
      tick();
      data_is_valid = 1'b0;
      tick();
      sampling_strobe  = 1'b1;
      is_parity_stage  = 1'b1;
      serial_in_synced = pb;
      tick();
      sampling_strobe  = 1'b0;
      is_parity_stage  = 1'b0;
      serial_in_synced = 1'b1;
      tick();
      tick();
      sampling_strobe  = 1'b1;
      serial_in_synced = sbit;
      tick();
      sampling_strobe  = 1'b0;
      serial_in_synced = 1'b1;
   endtask

   task automatic pop_check(input string name);
      entry_t e;
      int unsigned waited;
      waited = 0;
      while (!out_valid && waited < 10) begin
         tick();
         waited++;
      end
      if (!out_valid) begin
         chk({name, "_valid"}, 32'(out_valid), 32'd1);
         return;
      end
      if (sb_q.size() == 0) begin
         chk({name, "_unexpected"}, 32'(out_data), 32'hFFFF_FFFF);
         return;
      end
      e = sb_q.pop_front();
      chk({name, "_data"}, 32'(out_data), 32'(e.d));
      chk({name, "_par"},  32'(out_parity_error), 32'(e.par));
      chk({name, "_frm"},  32'(out_framing_error), 32'(e.frm));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      entry_t     e;
      logic [7:0] d;

      vec[0] = '{d: 8'hA5, pb: 1'b0, sb: 1'b1, ep: 1'b0, ef: 1'b0};
      vec[1] = '{d: 8'h01, pb: 1'b0, sb: 1'b1, ep: 1'b1, ef: 1'b0};
      vec[2] = '{d: 8'h3C, pb: 1'b0, sb: 1'b0, ep: 1'b0, ef: 1'b1};
      vec[3] = '{d: 8'hFF, pb: 1'b1, sb: 1'b1, ep: 1'b1, ef: 1'b0};
      vec[4] = '{d: 8'h80, pb: 1'b1, sb: 1'b0, ep: 1'b0, ef: 1'b1};

      reset            = 1'b0;
      serial_in_synced = 1'b1;
      sampling_strobe  = 1'b0;
      is_parity_stage  = 1'b0;
      data_is_valid    = 1'b0;
      received_data    = '0;
      rx_enable        = 1'b1;
      out_ready        = 1'b0;
      clear_flags      = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_ovr",   32'(overrun), 32'd0);
      chk("rst_tmo",   32'(timeout), 32'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         e.d = vec[i].d;
         e.par = vec[i].ep & PAR_EN;
         e.frm = vec[i].ef;
         sb_q.push_back(e);
         send_frame(vec[i].d, vec[i].pb, vec[i].sb);
         chk($sformatf("vec%0d_n1_valid", i), 32'(out_valid), 32'd0);
         tick();
         chk($sformatf("vec%0d_n2_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_count", i), 32'(fifo_count), 32'd1);
         pop_check($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_after_pop", i), 32'(out_valid), 32'd0);
      end

      sampling_strobe = 1'b1;
      tick();
      sampling_strobe = 1'b0;
      repeat (3) tick();
      chk("idle_strobe_count", 32'(fifo_count), 32'd0);

      // Abandoned frame: second data_is_valid arrives in WAIT_STOP.
      data_is_valid = 1'b1;
      received_data = 8'h99;
      tick();
      data_is_valid = 1'b0;
      sampling_strobe = 1'b1;
      is_parity_stage = 1'b1;
      serial_in_synced = 1'b0;
      tick();
      sampling_strobe = 1'b0;
      is_parity_stage = 1'b0;
      serial_in_synced = 1'b1;
      sb_q.push_back('{d: 8'h66, frm: 1'b0, par: 1'b0});
      send_frame(8'h66, 1'b0, 1'b1);
      tick();
      chk("abandon_count", 32'(fifo_count), 32'd1);
      pop_check("abandon");

      for (int i = 0; i < 5; i++) begin
         d = 8'h10 + 8'(i);
         if (i < 4) sb_q.push_back('{d: d, frm: 1'b0, par: 1'b0});
         send_frame(d, ^d, 1'b1);
         tick();
      end
      chk("ovr_count", 32'(fifo_count), 32'd4);
      chk("ovr_flag",  32'(overrun), 32'd1);
      d = 8'h20;
      sb_q.push_back('{d: d, frm: 1'b0, par: 1'b0});
      send_frame(d, ^d, 1'b1);
      pop_check("full_pushpop");
      chk("full_pushpop_count", 32'(fifo_count), 32'd4);
      for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
      chk("drain_count", 32'(fifo_count), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("empty_pop_count", 32'(fifo_count), 32'd0);
      chk("empty_pop_valid", 32'(out_valid), 32'd0);
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      chk("ovr_clear", 32'(overrun), 32'd0);

      data_is_valid = 1'b1;
      received_data = 8'h42;
      tick();
      data_is_valid = 1'b0;
      repeat (4095) tick();
      chk("tmo_early", 32'(timeout), 32'd0);
      tick();
      chk("tmo_set", 32'(timeout), 32'd1);
      chk("tmo_count", 32'(fifo_count), 32'd0);
      sb_q.push_back('{d: 8'h55, frm: 1'b0, par: 1'b0});
      send_frame(8'h55, 1'b0, 1'b1);
      tick();
      chk("tmo_next_count", 32'(fifo_count), 32'd1);
      pop_check("tmo_next");
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      chk("tmo_clear", 32'(timeout), 32'd0);

      send_frame(8'h31, 1'b1, 1'b1);
      tick();
      send_frame(8'h32, 1'b1, 1'b1);
      tick();
      chk("pre_rst_count", 32'(fifo_count), 32'd2);
      data_is_valid = 1'b1;
      received_data = 8'h99;
      tick();
      data_is_valid = 1'b0;
      sampling_strobe = 1'b1;
      is_parity_stage = 1'b1;
      tick();
      sampling_strobe = 1'b0;
      is_parity_stage = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data",  32'(out_data), 32'd0);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_flags", {30'd0, overrun, timeout}, 32'd0);
      chk("mid_rst_errs",  {30'd0, out_parity_error, out_framing_error}, 32'd0);
      tick();
      reset = 1'b1;
      tick();
      sb_q.push_back('{d: 8'h77, frm: 1'b0, par: 1'b0});
      send_frame(8'h77, 1'b0, 1'b1);
      tick();
      chk("post_rst_count", 32'(fifo_count), 32'd1);
      pop_check("post_rst");
      chk("post_rst_empty", 32'(out_valid), 32'd0);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
